run_ctl: RTL and testbench

Run/step controller for the multicycle model machine. It owns the `sm_en` enable of the three-state FETCH/PREP/EXEC sequencer and provides free-run, single-cycle step, single-instruction step and HALT stop. It also counts executed machine cycles and completed instructions for the front-panel display. It sits between the panel switches/decoder and the sequencer; the sequencer advances on the falling edge, and this block updates on the rising edge.

---
 rtl/run_ctl_if.sv | 26 ++
 rtl/run_ctl.sv | 116 +++++++++++
 tb/tb_run_ctl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/run_ctl_if.sv
// Panel/sequencer-side signal bundle for the run/step controller.
// The slave modport is the controller; the master modport is the panel and sequencer side.
interface run_ctl_if #(
  parameter int CNT_W = 16
);
  logic             run;
  logic             step_cycle;
  logic             step_instr;
  logic             halt_req;
  logic [1:0]       sm;
  logic             sm_en;
  logic             running;
  logic             halted;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    output run, step_cycle, step_instr, halt_req, sm,
    input  sm_en, running, halted, cycle_cnt, instr_cnt
  );

  modport slave (
    input  run, step_cycle, step_instr, halt_req, sm,
    output sm_en, running, halted, cycle_cnt, instr_cnt
  );
endinterface

// File: rtl/run_ctl.sv
// Run/step controller: drives the sequencer enable for free-run, cycle step,
// instruction step and HALT, and counts issued cycles and completed instructions.
module run_ctl #(
  parameter int CNT_W = 16
) (
  input  logic     clk,
  input  logic     rst,
  run_ctl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_STEP_C,
    S_STEP_I,
    S_HALT
  } state_t;

  localparam logic [1:0]       SM_EXEC = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             sm_en_q, sm_en_d;
  logic             running_q, running_d;
  logic             halted_q, halted_d;
  logic             step_hlt_q, step_hlt_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

  // 11 is folded into EXEC so an illegal state always stops after one advance.
  logic stop_pt;
  assign stop_pt = bus.sm[1];

  // NOTE: every variable gets a default at the top of always_comb; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    sm_en_d    = 1'b0;
    step_hlt_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.run) begin
          state_d = S_RUN;
          sm_en_d = 1'b1;
        end else if (bus.step_instr) begin
          state_d = S_STEP_I;
          sm_en_d = 1'b1;
        end else if (bus.step_cycle) begin
          state_d    = S_STEP_C;
          sm_en_d    = 1'b1;
          // The sequencer has moved on by the next edge, so remember the HLT here.
          step_hlt_d = stop_pt && bus.halt_req;
        end
      end
      S_RUN: begin
        sm_en_d = 1'b1;
        if (stop_pt) begin
          if (bus.halt_req)  state_d = S_HALT;
          else if (!bus.run) state_d = S_IDLE;
        end
      end
      S_STEP_I: begin
        sm_en_d = 1'b1;
        if (stop_pt) state_d = bus.halt_req ? S_HALT : S_IDLE;
      end
      S_STEP_C: state_d = step_hlt_q ? S_HALT : S_IDLE;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase

    // running covers every advance issued in a run or instruction-step burst,
    // including the final one, but never overlaps halted.
    running_d = ((state_q == S_RUN) || (state_q == S_STEP_I) ||
                 (state_d == S_RUN) || (state_d == S_STEP_I)) &&
                (state_d != S_HALT);
    halted_d  = (state_d == S_HALT);

    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    if (sm_en_d && (cycle_cnt_q != CNT_MAX))
      cycle_cnt_d = cycle_cnt_q + CNT_ONE;
    if (sm_en_d && (bus.sm == SM_EXEC) && (instr_cnt_q != CNT_MAX))
      instr_cnt_d = instr_cnt_q + CNT_ONE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sm_en_q     <= 1'b0;
      running_q   <= 1'b0;
      halted_q    <= 1'b0;
      step_hlt_q  <= 1'b0;
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sm_en_q     <= sm_en_d;
      running_q   <= running_d;
      halted_q    <= halted_d;
      step_hlt_q  <= step_hlt_d;
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign bus.sm_en     = sm_en_q;
  assign bus.running   = running_q;
  assign bus.halted    = halted_q;
  assign bus.cycle_cnt = cycle_cnt_q;
  assign bus.instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_run_ctl.sv
// Directed bench for run_ctl: a behavioural FETCH/PREP/EXEC sequencer advances on
// the falling edge when sm_en is set; a second instance with CNT_W=2 covers saturation.
module tb_run_ctl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  run_ctl_if #(.CNT_W(16)) bus ();
  run_ctl_if #(.CNT_W(2))  bus2 ();

  run_ctl #(.CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
  run_ctl #(.CNT_W(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] sm1 = 2'b00;
  logic [1:0] sm2 = 2'b00;
  int         exec1 = 0;
  int         halt_base = 0;
  logic       halt_mode = 1'b0;

  always @(negedge clk) begin
    if (bus.sm_en) begin
      if (sm1 == 2'b10) exec1 <= exec1 + 1;
      sm1 <= (sm1 == 2'b10) ? 2'b00 : sm1 + 2'b01;
    end
  end

  always @(negedge clk) begin
    if (bus2.sm_en) sm2 <= (sm2 == 2'b10) ? 2'b00 : sm2 + 2'b01;
  end

  assign bus.sm        = sm1;
  assign bus2.sm       = sm2;
  assign bus.halt_req  = halt_mode && (sm1 == 2'b10) && ((exec1 - halt_base) == 1);
  assign bus2.halt_req = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_checks++;
    if (bus.sm_en !== 1'b0) begin n_fail++; $display("FAIL reset_sm_en: got %b want 0", bus.sm_en); end
    n_checks++;
    if (bus.running !== 1'b0) begin n_fail++; $display("FAIL reset_running: got %b want 0", bus.running); end
    n_checks++;
    if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", bus.halted); end
    n_checks++;
    if (bus.cycle_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cycle_cnt: got %0d want 0", bus.cycle_cnt); end
    n_checks++;
    if (bus.instr_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_instr_cnt: got %0d want 0", bus.instr_cnt); end
    n_checks++;
    if (bus2.cycle_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_cycle_cnt2: got %0d want 0", bus2.cycle_cnt); end
    rst = 1'b0;
  endtask

  task automatic test_free_run();
    do_reset();
    bus.run = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 7) bus.run = 1'b0;
      tick();
      n_checks++;
      if (bus.sm_en !== (i < 9)) begin n_fail++; $display("FAIL run_sm_en[%0d]: got %b want %b", i, bus.sm_en, (i < 9)); end
      n_checks++;
      if (bus.running !== (i < 9)) begin n_fail++; $display("FAIL run_running[%0d]: got %b want %b", i, bus.running, (i < 9)); end
    end
    n_checks++;
    if (sm1 !== 2'b00) begin n_fail++; $display("FAIL run_stop_sm: got %b want 00", sm1); end
    n_checks++;
    if (bus.cycle_cnt !== 16'd9) begin n_fail++; $display("FAIL run_cycle_cnt: got %0d want 9", bus.cycle_cnt); end
    n_checks++;
    if (bus.instr_cnt !== 16'd3) begin n_fail++; $display("FAIL run_instr_cnt: got %0d want 3", bus.instr_cnt); end
    n_checks++;
    if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL run_halted: got %b want 0", bus.halted); end
  endtask

  task automatic test_step_cycle();
    logic [1:0] exp_sm [3];
    exp_sm = '{2'b01, 2'b10, 2'b00};
    do_reset();
    for (int p = 0; p < 3; p++) begin
      bus.step_cycle = 1'b1;
      tick();
      bus.step_cycle = 1'b0;
      n_checks++;
      if (bus.sm_en !== 1'b1) begin n_fail++; $display("FAIL stepc_en[%0d]: got %b want 1", p, bus.sm_en); end
      n_checks++;
      if (bus.running !== 1'b0) begin n_fail++; $display("FAIL stepc_running[%0d]: got %b want 0", p, bus.running); end
      for (int k = 0; k < 3; k++) begin
        tick();
        n_checks++;
        if (bus.sm_en !== 1'b0) begin n_fail++; $display("FAIL stepc_idle_en[%0d.%0d]: got %b want 0", p, k, bus.sm_en); end
      end
      n_checks++;
      if (sm1 !== exp_sm[p]) begin n_fail++; $display("FAIL stepc_sm[%0d]: got %b want %b", p, sm1, exp_sm[p]); end
    end
    n_checks++;
    if (bus.cycle_cnt !== 16'd3) begin n_fail++; $display("FAIL stepc_cycle_cnt: got %0d want 3", bus.cycle_cnt); end
    n_checks++;
    if (bus.instr_cnt !== 16'd1) begin n_fail++; $display("FAIL stepc_instr_cnt: got %0d want 1", bus.instr_cnt); end
  endtask

  task automatic test_step_instr();
    do_reset();
    bus.step_cycle = 1'b1;
    tick();
    bus.step_cycle = 1'b0;
    tick();
    tick();
    n_checks++;
    if (sm1 !== 2'b01) begin n_fail++; $display("FAIL stepi_pre_sm: got %b want 01", sm1); end
    bus.step_instr = 1'b1;
    tick();
    bus.step_instr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus.sm_en !== (i < 2)) begin n_fail++; $display("FAIL stepi_en[%0d]: got %b want %b", i, bus.sm_en, (i < 2)); end
      n_checks++;
      if (bus.running !== (i < 2)) begin n_fail++; $display("FAIL stepi_running[%0d]: got %b want %b", i, bus.running, (i < 2)); end
      if (i < 2) tick();
    end
    n_checks++;
    if (sm1 !== 2'b00) begin n_fail++; $display("FAIL stepi_sm: got %b want 00", sm1); end
    n_checks++;
    if (bus.cycle_cnt !== 16'd3) begin n_fail++; $display("FAIL stepi_cycle_cnt: got %0d want 3", bus.cycle_cnt); end
    n_checks++;
    if (bus.instr_cnt !== 16'd1) begin n_fail++; $display("FAIL stepi_instr_cnt: got %0d want 1", bus.instr_cnt); end
  endtask

  task automatic test_halt();
    do_reset();
    halt_base = exec1;
    halt_mode = 1'b1;
    bus.run   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (bus.sm_en !== 1'b1) begin n_fail++; $display("FAIL halt_run_en[%0d]: got %b want 1", i, bus.sm_en); end
    end
    n_checks++;
    if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag_early: got %b want 1", bus.halted); end
    tick();
    halt_mode = 1'b0;
    n_checks++;
    if (bus.sm_en !== 1'b0) begin n_fail++; $display("FAIL halt_en: got %b want 0", bus.sm_en); end
    n_checks++;
    if (sm1 !== 2'b00) begin n_fail++; $display("FAIL halt_sm: got %b want 00", sm1); end
    n_checks++;
    if (bus.instr_cnt !== 16'd2) begin n_fail++; $display("FAIL halt_instr_cnt: got %0d want 2", bus.instr_cnt); end
    n_checks++;
    if (bus.running !== 1'b0) begin n_fail++; $display("FAIL halt_running: got %b want 0", bus.running); end
    for (int i = 0; i < 4; i++) begin
      bus.step_cycle = (i == 0);
      bus.step_instr = (i == 1);
      bus.run        = (i != 2);
      tick();
      n_checks++;
      if (bus.sm_en !== 1'b0) begin n_fail++; $display("FAIL halt_ignore_en[%0d]: got %b want 0", i, bus.sm_en); end
    end
    bus.step_cycle = 1'b0;
    bus.step_instr = 1'b0;
    bus.run        = 1'b0;
    n_checks++;
    if (bus.cycle_cnt !== 16'd6) begin n_fail++; $display("FAIL halt_cycle_cnt: got %0d want 6", bus.cycle_cnt); end
    n_checks++;
    if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL halt_sticky: got %b want 1", bus.halted); end
    do_reset();
    n_checks++;
    if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL halt_rst_halted: got %b want 0", bus.halted); end
    n_checks++;
    if (bus.cycle_cnt !== 16'd0) begin n_fail++; $display("FAIL halt_rst_cycle: got %0d want 0", bus.cycle_cnt); end
    n_checks++;
    if (bus.instr_cnt !== 16'd0) begin n_fail++; $display("FAIL halt_rst_instr: got %0d want 0", bus.instr_cnt); end
    tick();
    n_checks++;
    if (bus.sm_en !== 1'b0) begin n_fail++; $display("FAIL halt_rst_idle_en: got %b want 0", bus.sm_en); end
  endtask

  task automatic test_priority();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i == 0) begin
        bus.run        = 1'b1;
        bus.step_instr = 1'b1;
      end
      if (i == 4) bus.run = 1'b0;
      bus.step_cycle = (i == 0) || (i == 1);
      tick();
      bus.step_cycle = 1'b0;
      bus.step_instr = 1'b0;
      n_checks++;
      if (bus.sm_en !== (i < 6)) begin n_fail++; $display("FAIL prio_en[%0d]: got %b want %b", i, bus.sm_en, (i < 6)); end
      if (i == 0) begin
        n_checks++;
        if (bus.running !== 1'b1) begin n_fail++; $display("FAIL prio_running: got %b want 1", bus.running); end
      end
    end
    n_checks++;
    if (bus.cycle_cnt !== 16'd6) begin n_fail++; $display("FAIL prio_cycle_cnt: got %0d want 6", bus.cycle_cnt); end
    n_checks++;
    if (bus.instr_cnt !== 16'd2) begin n_fail++; $display("FAIL prio_instr_cnt: got %0d want 2", bus.instr_cnt); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_c;
    logic [1:0] exp_i;
    int         adv;
    do_reset();
    bus2.run = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (i == 10) bus2.run = 1'b0;
      tick();
      adv   = (i < 12) ? i + 1 : 12;
      exp_c = (adv > 3) ? 2'd3 : 2'(adv);
      exp_i = ((adv / 3) > 3) ? 2'd3 : 2'(adv / 3);
      n_checks++;
      if (bus2.sm_en !== (i < 12)) begin n_fail++; $display("FAIL sat_en[%0d]: got %b want %b", i, bus2.sm_en, (i < 12)); end
      n_checks++;
      if (bus2.cycle_cnt !== exp_c) begin n_fail++; $display("FAIL sat_cycle[%0d]: got %0d want %0d", i, bus2.cycle_cnt, exp_c); end
      n_checks++;
      if (bus2.instr_cnt !== exp_i) begin n_fail++; $display("FAIL sat_instr[%0d]: got %0d want %0d", i, bus2.instr_cnt, exp_i); end
    end
  endtask

  initial begin
    bus.run         = 1'b0;
    bus.step_cycle  = 1'b0;
    bus.step_instr  = 1'b0;
    bus2.run        = 1'b0;
    bus2.step_cycle = 1'b0;
    bus2.step_instr = 1'b0;
    test_reset();
    test_free_run();
    test_step_cycle();
    test_step_instr();
    test_halt();
    test_priority();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
